// File: rtl/axis_frame_pkg.sv
// Shared types and constants for the 112-bit frame serializer.
// FRAME_CHECKSUM_EN appends an XOR checksum word to every frame.
package axis_frame_pkg;

  localparam int unsigned WORD_W          = 16;
  localparam int unsigned FRAME_W         = 112;
  localparam int unsigned WORDS_PER_FRAME = 7;
  localparam int unsigned IDX_W           = 3;

`ifdef FRAME_CHECKSUM_EN
  localparam int unsigned LAST_IDX = WORDS_PER_FRAME;
`else
  localparam int unsigned LAST_IDX = WORDS_PER_FRAME - 1;
`endif

  typedef enum logic {
    IDLE,
    SEND
  } state_t;

  function automatic logic [WORD_W-1:0] frame_xor(input logic [FRAME_W-1:0] frame);
    logic [WORD_W-1:0] acc;
    acc = '0;
    for (int unsigned k = 0; k < WORDS_PER_FRAME; k++) begin
      acc = acc ^ frame[k*WORD_W +: WORD_W];
    end
    return acc;
  endfunction

endpackage

// File: rtl/axis_frame_fifo.sv
// Synchronous first-word-fall-through frame FIFO; rd_data is the head whenever ~empty.
// Pointers carry one extra wrap bit to tell full from empty.
module axis_frame_fifo
  import axis_frame_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = FRAME_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             do_wr, do_rd;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign rd_data = mem_q[rd_ptr_q[AW-1:0]];

  // A write while full is legal only when the head leaves in the same cycle.
  assign do_rd = rd_en && !empty;
  assign do_wr = wr_en && (!full || do_rd);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_wr) begin
      mem_d[wr_ptr_q[AW-1:0]] = wr_data;
      wr_ptr_d                = wr_ptr_q + (AW+1)'(1);
    end
    if (do_rd) begin
      rd_ptr_d = rd_ptr_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

endmodule

// File: rtl/axis_frame_serializer.sv
// Buffers valid-only 112-bit frames and serializes each into 16-bit AXI4-Stream words.
// FRAME_CHECKSUM_EN adds an 8th XOR checksum word carrying tlast.
module axis_frame_serializer
  import axis_frame_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH      = 4,
  parameter int unsigned DROP_CNTR_WIDTH = 32
) (
  input  logic                       aclk,
  input  logic                       aresetn,
  input  logic [FRAME_W-1:0]         s_axis_tdata,
  input  logic                       s_axis_tvalid,
  output logic [WORD_W-1:0]          m_axis_tdata,
  output logic                       m_axis_tvalid,
  input  logic                       m_axis_tready,
  output logic                       m_axis_tlast,
  output logic [DROP_CNTR_WIDTH-1:0] sts_drop_cnt
);

  state_t                     state_q, state_d;
  logic [IDX_W-1:0]           idx_q, idx_d;
  logic [FRAME_W-1:0]         shreg_q, shreg_d;
  logic [DROP_CNTR_WIDTH-1:0] drop_q, drop_d;
`ifdef FRAME_CHECKSUM_EN
  logic [WORD_W-1:0]          csum_q, csum_d;
`endif

  logic               fifo_full, fifo_empty;
  logic [FRAME_W-1:0] fifo_rd_data;
  logic               pop, accept, hs, is_last, sending;

  axis_frame_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (FRAME_W)
  ) u_fifo (
    .clk     (aclk),
    .rst_n   (aresetn),
    .wr_en   (accept),
    .wr_data (s_axis_tdata),
    .rd_en   (pop),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign sending = (state_q == SEND);
  assign is_last = (idx_q == IDX_W'(LAST_IDX));
  assign hs      = sending && m_axis_tready;
  assign accept  = s_axis_tvalid && (!fifo_full || pop);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    shreg_d = shreg_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          shreg_d = fifo_rd_data;
          idx_d   = '0;
          state_d = SEND;
        end
      end
      SEND: begin
        if (hs) begin
          if (!is_last) begin
            idx_d   = idx_q + IDX_W'(1);
            shreg_d = shreg_q >> WORD_W;
          end else if (!fifo_empty) begin
            // Chain straight into the next frame so the stream has no bubble.
            pop     = 1'b1;
            shreg_d = fifo_rd_data;
            idx_d   = '0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef FRAME_CHECKSUM_EN
  always_comb begin
    csum_d = csum_q;
    if (pop) begin
      csum_d = frame_xor(fifo_rd_data);
    end
  end
`endif

  always_comb begin
    drop_d = drop_q;
    if (s_axis_tvalid && !accept && !(&drop_q)) begin
      drop_d = drop_q + DROP_CNTR_WIDTH'(1);
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q <= IDLE;
      idx_q   <= '0;
      shreg_q <= '0;
      drop_q  <= '0;
`ifdef FRAME_CHECKSUM_EN
      csum_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      shreg_q <= shreg_d;
      drop_q  <= drop_d;
`ifdef FRAME_CHECKSUM_EN
      csum_q  <= csum_d;
`endif
    end
  end

  always_comb begin
    m_axis_tvalid = sending;
    m_axis_tlast  = sending && is_last;
    m_axis_tdata  = '0;
    if (sending) begin
`ifdef FRAME_CHECKSUM_EN
      m_axis_tdata = is_last ? csum_q : shreg_q[WORD_W-1:0];
`else
      m_axis_tdata = shreg_q[WORD_W-1:0];
`endif
    end
  end

  assign sts_drop_cnt = drop_q;

endmodule
